// File: rtl/subterranean_lwc_pkg.sv
// Shared definitions for the Subterranean LWC wrapper.
// Holds the output-buffer occupancy state encoding.
package subterranean_lwc_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_t;

endpackage

// File: rtl/subterranean_lwc_buffer_out.sv
// Two-entry registered output buffer from the Subterranean core to the LWC do port.
// Handshake outputs decode the state register only, so dout_ready never reaches din_ready.
module subterranean_lwc_buffer_out
    import subterranean_lwc_pkg::*;
#(
    parameter int G_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [G_WIDTH-1:0] din,
    input  logic               din_last,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [G_WIDTH-1:0] dout,
    output logic               dout_last,
    output logic               dout_valid,
    input  logic               dout_ready
);

    buf_state_t       r_state;
    logic [G_WIDTH:0] r_main;
    logic [G_WIDTH:0] r_skid;

    logic w_acc;
    logic w_pop;

    assign din_ready  = (r_state != ST_TWO);
    assign dout_valid = (r_state != ST_EMPTY);
    assign dout       = r_main[G_WIDTH-1:0];
    assign dout_last  = r_main[G_WIDTH];

    assign w_acc = din_valid & din_ready;
    assign w_pop = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_state <= ST_ONE;
                        r_main  <= {din_last, din};
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_pop) begin
                        r_state <= ST_TWO;
                        r_skid  <= {din_last, din};
                    end else if (!w_acc && w_pop) begin
                        r_state <= ST_EMPTY;
                    end else if (w_acc && w_pop) begin
                        r_main  <= {din_last, din};
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_state <= ST_ONE;
                        r_main  <= r_skid;
                    end
                end
                // 2'b11 is unreachable; fall back to a known-empty buffer
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subterranean_lwc_buffer_out.sv
// Self-checking bench for subterranean_lwc_buffer_out.
// Directed vector table followed by random traffic against a queue model.
module tb_subterranean_lwc_buffer_out;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        din_last;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] dout;
    logic        dout_last;
    logic        dout_valid;
    logic        dout_ready;

    int n_checks;
    int n_fails;

    subterranean_lwc_buffer_out #(.G_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_last   (din_last),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] din;
        logic        lst;
        logic        v;
        logic        rdy;
        logic        e_dv;
        logic        e_drdy;
        logic        chk;
        logic [31:0] e_d;
        logic        e_l;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] d, input logic l,
                       input logic v, input logic rd, input logic edv,
                       input logic edr, input logic chk, input logic [31:0] ed,
                       input logic el);
        vec_t x;
        x.rst = r; x.din = d; x.lst = l; x.v = v; x.rdy = rd;
        x.e_dv = edv; x.e_drdy = edr; x.chk = chk; x.e_d = ed; x.e_l = el;
        vecs.push_back(x);
    endtask

    task automatic check(input string nm, input int idx, input logic edv,
                         input logic edr, input logic chk,
                         input logic [31:0] ed, input logic el);
        logic bad;
        n_checks++;
        bad = (dout_valid !== edv) || (din_ready !== edr);
        if (chk) bad = bad || (dout !== ed) || (dout_last !== el);
        if (bad) begin
            n_fails++;
            $display("FAIL %s[%0d]: got dv=%b rdy=%b d=%h l=%b, want dv=%b rdy=%b d=%h l=%b (data checked=%b)",
                     nm, idx, dout_valid, din_ready, dout, dout_last,
                     edv, edr, ed, el, chk);
        end
    endtask

    logic [32:0] model_q[$];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1; din = '0; din_last = 1'b0;
        din_valid = 1'b0; dout_ready = 1'b0;

        // reset held two cycles with a word offered
        add(1, 32'hDEADBEEF, 0, 1, 0,  0, 1, 1, 32'h0, 0);
        add(1, 32'hDEADBEEF, 0, 1, 0,  0, 1, 1, 32'h0, 0);
        // streaming 1..8, last on 8
        for (int k = 1; k <= 8; k++)
            add(0, k, (k == 8), 1, 1,  1, 1, 1, k, (k == 8));
        add(0, 32'h0, 0, 0, 1,  0, 1, 0, 32'h0, 0);
        // backpressure
        add(0, 32'hA1, 0, 1, 0,  1, 1, 1, 32'hA1, 0);
        add(0, 32'hA2, 0, 1, 0,  1, 0, 1, 32'hA1, 0);
        add(0, 32'hA3, 0, 1, 0,  1, 0, 1, 32'hA1, 0);
        add(0, 32'hA3, 0, 1, 1,  1, 1, 1, 32'hA2, 0);
        add(0, 32'hA3, 0, 1, 1,  1, 1, 1, 32'hA3, 0);
        add(0, 32'h0,  0, 0, 1,  0, 1, 0, 32'h0, 0);
        // simultaneous accept and pop in ONE
        add(0, 32'h11, 0, 1, 0,  1, 1, 1, 32'h11, 0);
        add(0, 32'h22, 0, 1, 1,  1, 1, 1, 32'h22, 0);
        add(0, 32'h0,  0, 0, 1,  0, 1, 0, 32'h0, 0);
        // reset while full flushes both words
        add(0, 32'h55, 0, 1, 0,  1, 1, 1, 32'h55, 0);
        add(0, 32'h66, 1, 1, 0,  1, 0, 1, 32'h55, 0);
        add(1, 32'h99, 1, 1, 1,  0, 1, 1, 32'h0, 0);
        add(0, 32'h77, 0, 1, 0,  1, 1, 1, 32'h77, 0);
        add(0, 32'h0,  0, 0, 1,  0, 1, 0, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            din        = vecs[i].din;
            din_last   = vecs[i].lst;
            din_valid  = vecs[i].v;
            dout_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check("vec", i, vecs[i].e_dv, vecs[i].e_drdy, vecs[i].chk,
                  vecs[i].e_d, vecs[i].e_l);
        end

        // random traffic, model is a plain FIFO of capacity two
        rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic        v, rd, l, acc, pop;
            logic [31:0] d;
            logic [32:0] head;
            head = (model_q.size() > 0) ? model_q[0] : 33'h0;
            check("rand", c, model_q.size() > 0, model_q.size() < 2,
                  model_q.size() > 0, head[31:0], head[32]);
            v  = ($urandom_range(0, 99) < 70);
            rd = ($urandom_range(0, 99) < 55);
            d  = $urandom;
            l  = $urandom_range(0, 1);
            din = d; din_last = l; din_valid = v; dout_ready = rd;
            acc = v && (model_q.size() < 2);
            pop = rd && (model_q.size() > 0);
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back({l, d});
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
